// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, widths and issue-queue entry types.
package alu_pkg;
    localparam int WIDTH  = 32;
    localparam int ALU_OP = 4;
    localparam int TAG_W  = 6;

    typedef enum logic [ALU_OP-1:0] {
        ADD = 4'h0, SUB = 4'h1, SLL = 4'h2, SLA = 4'h3, SRL = 4'h4, SRA = 4'h5, XOR = 4'h6,
        OR  = 4'h7, AND = 4'h8, BEQ = 4'h9, BNE = 4'hA, BLT = 4'hB, BGE = 4'hC, SLT = 4'hD
    } alu_op_e;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] val;
    } src_t;

    typedef struct packed {
        logic              valid;
        logic [ALU_OP-1:0] op;
        logic [4:0]        shamt;
        logic              shamt_sel;
        src_t              rs1;
        src_t              rs2;
        logic [TAG_W-1:0]  rd_tag;
    } iq_entry_t;

    // capture a broadcast result into a source that is still waiting on it
    function automatic src_t wake(src_t s, logic wb_valid, logic [TAG_W-1:0] wb_tag,
                                  logic [WIDTH-1:0] wb_data);
        return (!s.rdy && wb_valid && wb_tag == s.tag) ? {1'b1, s.tag, wb_data} : s;
    endfunction
endpackage

// File: rtl/alu_iq_select.sv
// alu_iq_select: find-first-set arbiter over the ready vector, lowest index wins.
module alu_iq_select #(
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IW-1:0]    idx
);
    assign grant = req & (~req + DEPTH'(1));

    always_comb begin
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing issue queue for one ALU lane, with writeback snooping
// and oldest-ready selection into a registered execute slot.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALU_OP-1:0] in_op,
    input  logic [4:0]        in_shamt,
    input  logic              in_shamt_sel,
    input  logic              in_rs1_rdy,
    input  logic [TAG_W-1:0]  in_rs1_tag,
    input  logic [WIDTH-1:0]  in_rs1_val,
    input  logic              in_rs2_rdy,
    input  logic [TAG_W-1:0]  in_rs2_tag,
    input  logic [WIDTH-1:0]  in_rs2_val,
    input  logic [TAG_W-1:0]  in_rd_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [ALU_OP-1:0] iss_op,
    output logic [WIDTH-1:0]  iss_rs1,
    output logic [WIDTH-1:0]  iss_rs2,
    output logic [4:0]        iss_shamt,
    output logic [TAG_W-1:0]  iss_rd_tag
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    iq_entry_t        q    [DEPTH];
    iq_entry_t        nq   [DEPTH];
    iq_entry_t        woke [DEPTH+1];
    iq_entry_t        in_e;
    logic [CW-1:0]    count, wr_slot;
    logic [DEPTH-1:0] rdy_vec, grant;
    logic [IW-1:0]    idx;
    logic             pick, acc;

    alu_iq_select #(.DEPTH(DEPTH), .IW(IW)) u_sel (.req(rdy_vec), .grant(grant), .idx(idx));

    assign in_ready = count != CW'(DEPTH);
    assign acc      = in_valid && in_ready;
    assign pick     = (!iss_valid || iss_ready) && |grant;
    assign wr_slot  = pick ? count - CW'(1) : count;

    // selection sees registered readiness, so a wakeup only counts from the next cycle
    always_comb begin
        woke[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]     = q[i];
            woke[i].rs1 = wake(q[i].rs1, wb_valid, wb_tag, wb_data);
            woke[i].rs2 = wake(q[i].rs2, wb_valid, wb_tag, wb_data);
            rdy_vec[i]  = q[i].valid && q[i].rs1.rdy && q[i].rs2.rdy;
        end
    end

    always_comb begin
        in_e = {1'b1, in_op, in_shamt, in_shamt_sel,
                wake({in_rs1_rdy, in_rs1_tag, in_rs1_val}, wb_valid, wb_tag, wb_data),
                wake({in_rs2_rdy, in_rs2_tag, in_rs2_val}, wb_valid, wb_tag, wb_data),
                in_rd_tag};
        for (int i = 0; i < DEPTH; i++) begin
            nq[i] = (pick && i >= int'(idx)) ? woke[i+1] : woke[i];
            if (acc && i == int'(wr_slot)) nq[i] = in_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '{default: '0};
            count      <= '0;
            iss_valid  <= 1'b0;
            iss_op     <= '0;
            iss_rs1    <= '0;
            iss_rs2    <= '0;
            iss_shamt  <= '0;
            iss_rd_tag <= '0;
        end else if (flush) begin
            q         <= '{default: '0};
            count     <= '0;
            iss_valid <= 1'b0;
        end else begin
            q     <= nq;
            count <= count + CW'(acc) - CW'(pick);
            if (!iss_valid || iss_ready) iss_valid <= pick;
            if (pick) begin
                iss_op     <= q[idx].op;
                iss_rs1    <= q[idx].rs1.val;
                iss_rs2    <= q[idx].rs2.val;
                iss_shamt  <= q[idx].shamt_sel ? q[idx].rs2.val[4:0] : q[idx].shamt;
                iss_rd_tag <= q[idx].rd_tag;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench for the ALU issue queue; expected issues are
// queued as stimulus is driven and compared on each iss_valid && iss_ready handshake.
module tb_alu_issue_queue;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  shamt;
        logic [5:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_shamt_sel;
    logic [3:0]  in_op;
    logic [4:0]  in_shamt;
    logic        in_rs1_rdy, in_rs2_rdy;
    logic [5:0]  in_rs1_tag, in_rs2_tag, in_rd_tag;
    logic [31:0] in_rs1_val, in_rs2_val;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_op;
    logic [31:0] iss_rs1, iss_rs2;
    logic [4:0]  iss_shamt;
    logic [5:0]  iss_rd_tag;

    exp_t sb [$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_shamt(in_shamt), .in_shamt_sel(in_shamt_sel),
        .in_rs1_rdy(in_rs1_rdy), .in_rs1_tag(in_rs1_tag), .in_rs1_val(in_rs1_val),
        .in_rs2_rdy(in_rs2_rdy), .in_rs2_tag(in_rs2_tag), .in_rs2_val(in_rs2_val),
        .in_rd_tag(in_rd_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_shamt(iss_shamt), .iss_rd_tag(iss_rd_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [4:0] sh, input logic ss,
                            input logic r1r, input logic [5:0] r1t, input logic [31:0] r1v,
                            input logic r2r, input logic [5:0] r2t, input logic [31:0] r2v,
                            input logic [5:0] rd);
        in_valid = 1'b1; in_op = op; in_shamt = sh; in_shamt_sel = ss;
        in_rs1_rdy = r1r; in_rs1_tag = r1t; in_rs1_val = r1v;
        in_rs2_rdy = r2r; in_rs2_tag = r2t; in_rs2_val = r2v;
        in_rd_tag = rd;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] sh, input logic [5:0] rd);
        sb.push_back('{op: op, rs1: r1, rs2: r2, shamt: sh, rd: rd});
    endtask

    task automatic drive_wb(input logic [5:0] t, input logic [31:0] d);
        wb_valid = 1'b1; wb_tag = t; wb_data = d;
    endtask

    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready) begin
            if (sb.size() == 0) chk("issue_without_expectation", 64'(iss_valid), 64'd0);
            else begin
                m_e = sb.pop_front();
                chk("sb_op", 64'(iss_op), 64'(m_e.op));
                chk("sb_rs1", 64'(iss_rs1), 64'(m_e.rs1));
                chk("sb_rs2", 64'(iss_rs2), 64'(m_e.rs2));
                chk("sb_shamt", 64'(iss_shamt), 64'(m_e.shamt));
                chk("sb_rd_tag", 64'(iss_rd_tag), 64'(m_e.rd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b1; wb_valid = 1'b0;
        drive_op(4'h0, 5'h0, 1'b0, 1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 32'h0, 6'h0);
        in_valid = 1'b0; wb_tag = '0; wb_data = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_op", 64'(iss_op), 64'd0);
        chk("rst_iss_rs1", 64'(iss_rs1), 64'd0);
        chk("rst_iss_rs2", 64'(iss_rs2), 64'd0);
        chk("rst_iss_shamt", 64'(iss_shamt), 64'd0);
        chk("rst_iss_rd_tag", 64'(iss_rd_tag), 64'd0);
        tick();

        // ready ADD: accepted at edge 1, issued at edge 2
        drive_op(ADD, 5'd0, 1'b0, 1'b1, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7, 6'd3);
        push(ADD, 32'd5, 32'd7, 5'd0, 6'd3);
        tick(); @(negedge clk);
        chk("add_not_yet", 64'(iss_valid), 64'd0);
        tick(); @(negedge clk);
        chk("add_valid", 64'(iss_valid), 64'd1);
        chk("add_rd_tag", 64'(iss_rd_tag), 64'd3);
        tick(); @(negedge clk);
        chk("add_drained", 64'(iss_valid), 64'd0);

        // SUB waiting on tag 9; a broadcast on another tag must not wake it
        drive_op(SUB, 5'd0, 1'b0, 1'b1, 6'd1, 32'h20, 1'b0, 6'd9, 32'hBAD, 6'd4);
        push(SUB, 32'h20, 32'h10, 5'd0, 6'd4);
        tick(); @(negedge clk);
        chk("sub_wait0", 64'(iss_valid), 64'd0);
        drive_wb(6'd8, 32'hDEAD);
        tick(); @(negedge clk);
        chk("sub_wrong_tag", 64'(iss_valid), 64'd0);
        drive_wb(6'd9, 32'h10);
        tick(); @(negedge clk);
        chk("sub_wake_edge", 64'(iss_valid), 64'd0);
        tick(); @(negedge clk);
        chk("sub_issued", 64'(iss_valid), 64'd1);
        chk("sub_rs2", 64'(iss_rs2), 64'h10);
        tick();

        // wakeup in the accept cycle is captured on entry
        drive_op(SUB, 5'd0, 1'b0, 1'b1, 6'd1, 32'h21, 1'b0, 6'd9, 32'hBAD, 6'd5);
        drive_wb(6'd9, 32'h33);
        push(SUB, 32'h21, 32'h33, 5'd0, 6'd5);
        tick(); @(negedge clk);
        chk("sub2_not_yet", 64'(iss_valid), 64'd0);
        tick(); @(negedge clk);
        chk("sub2_issued", 64'(iss_valid), 64'd1);
        chk("sub2_rs2", 64'(iss_rs2), 64'h33);
        tick();

        // fill: A blocked on tag 2, B..E ready; B takes the held output slot
        iss_ready = 1'b0;
        drive_op(ADD, 5'd0, 1'b0, 1'b0, 6'd2, 32'h0, 1'b1, 6'd0, 32'd1, 6'd10); tick();
        drive_op(XOR, 5'd0, 1'b0, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22, 6'd11); tick();
        drive_op(OR, 5'd0, 1'b0, 1'b1, 6'd0, 32'h33, 1'b1, 6'd0, 32'h44, 6'd12); tick();
        drive_op(AND, 5'd0, 1'b0, 1'b1, 6'd0, 32'h55, 1'b1, 6'd0, 32'h66, 6'd13); tick();
        drive_op(SLT, 5'd0, 1'b0, 1'b1, 6'd0, 32'h88, 1'b1, 6'd0, 32'h99, 6'd14); tick();
        push(XOR, 32'h11, 32'h22, 5'd0, 6'd11);
        push(OR, 32'h33, 32'h44, 5'd0, 6'd12);
        push(ADD, 32'h77, 32'd1, 5'd0, 6'd10);
        push(AND, 32'h55, 32'h66, 5'd0, 6'd13);
        push(SLT, 32'h88, 32'h99, 5'd0, 6'd14);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_held_rd", 64'(iss_rd_tag), 64'd11);
        drive_op(SRA, 5'd0, 1'b0, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 6'd15);
        tick(); @(negedge clk);
        chk("full_rejects", 64'(in_ready), 64'd0);
        iss_ready = 1'b1;
        drive_wb(6'd2, 32'h77);
        tick(); @(negedge clk);
        chk("full_in_ready_back", 64'(in_ready), 64'd1);
        chk("entry1_first", 64'(iss_rd_tag), 64'd12);
        tick(); @(negedge clk);
        chk("woken_oldest_next", 64'(iss_rd_tag), 64'd10);
        tick(); @(negedge clk);
        chk("then_d", 64'(iss_rd_tag), 64'd13);
        tick(); @(negedge clk);
        chk("then_e", 64'(iss_rd_tag), 64'd14);
        tick(); @(negedge clk);
        chk("fill_drained", 64'(iss_valid), 64'd0);

        // shamt from rs2, then backpressure hold
        iss_ready = 1'b0;
        drive_op(SLL, 5'h1F, 1'b1, 1'b1, 6'd0, 32'hABCD, 1'b1, 6'd0, 32'h25, 6'd20);
        push(SLL, 32'hABCD, 32'h25, 5'd5, 6'd20);
        tick();
        drive_op(SRL, 5'd3, 1'b0, 1'b1, 6'd0, 32'hF0, 1'b1, 6'd0, 32'h99, 6'd21);
        push(SRL, 32'hF0, 32'h99, 5'd3, 6'd21);
        tick(); @(negedge clk);
        chk("sll_shamt", 64'(iss_shamt), 64'd5);
        for (int k = 0; k < 3; k++) begin
            tick(); @(negedge clk);
            chk("hold_valid", 64'(iss_valid), 64'd1);
            chk("hold_op", 64'(iss_op), 64'(SLL));
            chk("hold_rs1", 64'(iss_rs1), 64'hABCD);
            chk("hold_rs2", 64'(iss_rs2), 64'h25);
            chk("hold_shamt", 64'(iss_shamt), 64'd5);
            chk("hold_rd", 64'(iss_rd_tag), 64'd20);
        end
        iss_ready = 1'b1;
        tick(); @(negedge clk);
        chk("after_hold_rd", 64'(iss_rd_tag), 64'd21);
        chk("after_hold_shamt", 64'(iss_shamt), 64'd3);
        tick(); @(negedge clk);
        chk("hold_drained", 64'(iss_valid), 64'd0);

        // flush with 3 queued plus a held issue, alongside a new enqueue
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_op(ADD, 5'd0, 1'b0, 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'h1, 6'(30 + k));
            tick();
        end
        @(negedge clk);
        chk("pre_flush_valid", 64'(iss_valid), 64'd1);
        chk("pre_flush_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b1;
        drive_op(SUB, 5'd0, 1'b0, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h6, 6'd40);
        drive_wb(6'd7, 32'h1);
        tick(); @(negedge clk);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        iss_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); @(negedge clk);
            chk("flush_no_issue", 64'(iss_valid), 64'd0);
        end

        // asynchronous reset while an issue is held
        iss_ready = 1'b0;
        drive_op(XOR, 5'd0, 1'b0, 1'b1, 6'd0, 32'h5A, 1'b1, 6'd0, 32'hA5, 6'd50);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(iss_valid), 64'd0);
        chk("async_rst_rs1", 64'(iss_rs1), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        iss_ready = 1'b1;
        tick();
        drive_op(BNE, 5'd0, 1'b0, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4, 6'd51);
        push(BNE, 32'h3, 32'h4, 5'd0, 6'd51);
        tick();

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
